// File: rtl/iob_vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out fetches win over CPU accesses.
// Optional starvation guard enabled by defining VGA_FB_STARVE_GUARD_EN.
module iob_vga_fb_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       vga_addr,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              vga_underrun,
  input  logic              underrun_clr,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VGA  = 2'd1,
    SRC_CPU  = 2'd2
  } rd_src_t;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("MAX_WAIT must be in 1..255");
  end

  logic [ADDR_W-1:0] r_last_addr;
  logic              r_vga_pend;
  rd_src_t           r_rd_src;
  rd_src_t           w_rd_src_nxt;
  logic [DATA_W-1:0] r_vga_pixel;
  logic              r_vga_underrun;
  logic              r_cpu_rvalid;

  logic [ADDR_W-1:0] w_word;
  logic              w_change;
  logic              w_trip;
  logic              w_vga_gnt;
  logic              w_cpu_gnt;
  logic              w_unused_vga;

  assign w_word       = vga_addr[ADDR_W+3:4];
  assign w_change     = (w_word != r_last_addr);
  assign w_unused_vga = ^{vga_addr[31:ADDR_W+4], vga_addr[3:0]};

`ifdef VGA_FB_STARVE_GUARD_EN
  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);
  logic [7:0] r_wait_cnt;

  // Trip only while the CPU is still asking, so a stalled guard never blocks VGA.
  assign w_trip = cpu_valid && (r_wait_cnt == LP_MAX_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
    end else if (w_cpu_gnt) begin
      r_wait_cnt <= 8'd0;
    end else if (cpu_valid && (r_wait_cnt != LP_MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`else
  assign w_trip = 1'b0;
`endif

  // Arbitration: one memory access per cycle, nothing granted during reset.
  assign w_vga_gnt = !rst && r_vga_pend && !w_trip;
  assign w_cpu_gnt = !rst && !w_vga_gnt && cpu_valid;

  assign mem_en    = w_vga_gnt || w_cpu_gnt;
  assign mem_we    = w_cpu_gnt && cpu_we;
  assign mem_addr  = w_vga_gnt ? r_last_addr : cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign cpu_ready = w_cpu_gnt;

  always_comb begin
    w_rd_src_nxt = SRC_NONE;
    if (w_vga_gnt) begin
      w_rd_src_nxt = SRC_VGA;
    end else if (w_cpu_gnt && !cpu_we) begin
      w_rd_src_nxt = SRC_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_addr    <= '0;
      r_vga_pend     <= 1'b1;
      r_rd_src       <= SRC_NONE;
      r_vga_pixel    <= '0;
      r_vga_underrun <= 1'b0;
      r_cpu_rvalid   <= 1'b0;
    end else begin
      if (w_change) begin
        r_last_addr <= w_word;
        r_vga_pend  <= 1'b1;
      end else if (w_vga_gnt) begin
        r_vga_pend  <= 1'b0;
      end

      // A newer address overwriting an unserved one drops the old fetch.
      if (w_change && r_vga_pend && !w_vga_gnt) begin
        r_vga_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_vga_underrun <= 1'b0;
      end

      r_rd_src     <= w_rd_src_nxt;
      r_cpu_rvalid <= (w_rd_src_nxt == SRC_CPU);
      if (r_rd_src == SRC_VGA) begin
        r_vga_pixel <= mem_rdata;
      end
    end
  end

  // Read return is masked while reset is high so an in-flight read never pulses.
  assign cpu_rvalid   = r_cpu_rvalid && !rst;
  assign cpu_rdata    = mem_rdata;
  assign vga_pixel    = r_vga_pixel;
  assign vga_underrun = r_vga_underrun;

endmodule

// File: tb/tb_iob_vga_fb_arbiter.sv
// Directed bench for iob_vga_fb_arbiter with a small synchronous RAM model.
module tb_iob_vga_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
`ifdef VGA_FB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [31:0]       vga_addr;
  logic [DATA_W-1:0] vga_pixel;
  logic              vga_underrun;
  logic              underrun_clr;
  logic              cpu_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  iob_vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .vga_addr(vga_addr), .vga_pixel(vga_pixel),
    .vga_underrun(vga_underrun), .underrun_clr(underrun_clr),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: word 0 = 0x0ABC, word n = n*0x111; read data one cycle after access.
  logic [DATA_W-1:0] ram [0:63];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= (i == 0) ? 16'h0ABC : 16'(i * 32'h111);
    end else if (mem_en && mem_we) begin
      ram[mem_addr[5:0]] <= mem_wdata;
    end
    if (mem_en) mem_rdata <= ram[mem_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  int first_ready;

  initial begin
    rst = 1'b1; vga_addr = 32'h0; underrun_clr = 1'b0;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick(); tick();
    settle();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("rst_vga_pixel", 32'(vga_pixel), 32'h0);
    chk("rst_underrun", 32'(vga_underrun), 32'h0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);

    // First fetch of word 0 after reset release
    tick(); rst = 1'b0; cpu_valid = 1'b0; settle();
    chk("c1_mem_en", 32'(mem_en), 32'h1);
    chk("c1_mem_we", 32'(mem_we), 32'h0);
    chk("c1_mem_addr", 32'(mem_addr), 32'h0);
    tick(); settle();
    chk("c2_mem_en", 32'(mem_en), 32'h0);
    tick(); settle();
    chk("c3_vga_pixel", 32'(vga_pixel), 32'h0ABC);
    chk("c3_underrun", 32'(vga_underrun), 32'h0);

    // VGA scan: words 1..3 every 3 cycles
    for (int k = 1; k <= 3; k++) begin
      vga_addr = 32'(k) << 4; settle();
      chk("scan_idle_mem_en", 32'(mem_en), 32'h0);
      tick(); settle();
      chk("scan_mem_en", 32'(mem_en), 32'h1);
      chk("scan_mem_addr", 32'(mem_addr), 32'(k));
      tick(); settle();
      chk("scan_pixel_old", 32'(vga_pixel), (k == 1) ? 32'h0ABC : 32'((k - 1) * 32'h111));
      tick(); settle();
      chk("scan_pixel_new", 32'(vga_pixel), 32'(k * 32'h111));
    end

    // CPU write then read of word 5
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd5; cpu_wdata = 16'h00F0; settle();
    chk("wr_ready", 32'(cpu_ready), 32'h1);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h5);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h00F0);
    tick(); cpu_we = 1'b0; settle();
    chk("rd_ready", 32'(cpu_ready), 32'h1);
    chk("rd_mem_we", 32'(mem_we), 32'h0);
    chk("rd_rvalid_early", 32'(cpu_rvalid), 32'h0);
    tick(); cpu_valid = 1'b0; settle();
    chk("rd_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("rd_rdata", 32'(cpu_rdata), 32'h00F0);
    tick(); settle();
    chk("rd_rvalid_pulse", 32'(cpu_rvalid), 32'h0);

    // Starvation / underrun: VGA address changes every cycle while CPU reads word 2
    vga_addr = 32'h80;
    tick();
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd2;
    first_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      vga_addr = 32'(8 + i) << 4; settle();
      if (cpu_ready && first_ready == 0) first_ready = i;
      chk("starve_mem_addr", 32'(mem_addr), (GUARD && i == 5) ? 32'h2 : 32'(8 + i - 1));
      tick();
    end
    chk("starve_first_ready", 32'(first_ready), GUARD ? 32'h5 : 32'h0);
    // Cycle 6: word 12 skipped under the guard, word 13 fetched
    cpu_valid = !GUARD; settle();
    chk("c6_mem_addr", 32'(mem_addr), 32'hD);
    chk("c6_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("c6_rvalid", 32'(cpu_rvalid), 32'(GUARD));
    chk("c6_rdata", 32'(cpu_rdata), GUARD ? 32'h0222 : 32'h0CCC);
    chk("c6_underrun", 32'(vga_underrun), 32'(GUARD));
    tick(); settle();
    chk("c7_cpu_ready", 32'(cpu_ready), 32'(!GUARD));
    chk("c7_mem_en", 32'(mem_en), 32'(!GUARD));
    tick(); cpu_valid = 1'b0; underrun_clr = 1'b1; settle();
    chk("c8_vga_pixel", 32'(vga_pixel), 32'h0DDD);
    chk("c8_rvalid", 32'(cpu_rvalid), 32'(!GUARD));
    chk("c8_underrun", 32'(vga_underrun), 32'(GUARD));
    tick(); underrun_clr = 1'b0; settle();
    chk("clr_underrun", 32'(vga_underrun), 32'h0);

    // Reset in the cycle after a CPU read grant
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd3; settle();
    chk("mr_ready", 32'(cpu_ready), 32'h1);
    tick(); cpu_valid = 1'b0; rst = 1'b1; settle();
    chk("mr_rvalid_in_rst", 32'(cpu_rvalid), 32'h0);
    chk("mr_mem_en_in_rst", 32'(mem_en), 32'h0);
    tick(); settle();
    chk("mr_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("mr_vga_pixel", 32'(vga_pixel), 32'h0);
    chk("mr_underrun", 32'(vga_underrun), 32'h0);
    chk("mr_cpu_ready", 32'(cpu_ready), 32'h0);
    tick(); rst = 1'b0; settle();
    chk("mr_post_mem_en", 32'(mem_en), 32'h1);
    chk("mr_post_mem_addr", 32'(mem_addr), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
